fruit_control: RTL and testbench

- Control FSM that drives the fruit pixel datapath: issues new/draw/erase/move commands and consumes the datapath's fruit_drawn completion flag and fruit position.
- Paces motion from a frame-tick divider.
- Detects a slice (cursor inside the 16x16 sprite) or a miss (fruit past the bottom), and keeps the cut count and lives.
- Sits between the top-level game FSM (start/game_over) and the fruit datapath/VGA plot path.

---
 rtl/fruit_control.sv | 150 +++++++++++++++
 tb/tb_fruit_control.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_control.sv
// Fruit control FSM: sequences new/draw/erase/move commands for the fruit datapath,
// paces motion from a frame divider, detects slices and misses. Optional pause input: FRUIT_CTRL_PAUSE_EN.
module fruit_control #(
    parameter int FRAME_TICKS     = 833333,
    parameter int FRAMES_PER_MOVE = 4,
    parameter int BOTTOM_Y        = 104,
    parameter int START_LIVES     = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       fruit_drawn,
    input  logic [7:0] fruit_x_position,
    input  logic [6:0] fruit_y_position,
    input  logic [7:0] cursor_x,
    input  logic [6:0] cursor_y,
    input  logic       slice,
`ifdef FRUIT_CTRL_PAUSE_EN
    input  logic       pause,
`endif
    output logic       new_fruit,
    output logic       draw_fruit,
    output logic       erase_fruit,
    output logic       move_fruit,
    output logic       plot,
    output logic [7:0] number_of_fruits_cut,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int MW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_NEW, S_DRAW, S_GAP_D, S_WAIT,
        S_ERASE, S_GAP_E, S_MOVE, S_CHECK, S_GAME_OVER
    } state_t;

    state_t        state, next_state;
    logic [FW-1:0] frame_cnt;
    logic [MW-1:0] move_cnt;
    logic          cut_flag;
    logic [6:0]    prev_y;

    logic wait_run, frame_tick, last_move, hit, miss;

`ifdef FRUIT_CTRL_PAUSE_EN
    assign wait_run = (state == S_WAIT) && !pause;
`else
    assign wait_run = (state == S_WAIT);
`endif

    assign frame_tick = wait_run && (frame_cnt == FW'(FRAME_TICKS - 1));
    assign last_move  = (move_cnt == MW'(FRAMES_PER_MOVE - 1));

    // Widened by one bit so the far edge of a sprite near the screen edge cannot wrap.
    logic [8:0] fx9, cx9;
    logic [7:0] fy8, cy8;
    assign fx9 = {1'b0, fruit_x_position};
    assign cx9 = {1'b0, cursor_x};
    assign fy8 = {1'b0, fruit_y_position};
    assign cy8 = {1'b0, cursor_y};
    assign hit = slice && (cx9 >= fx9) && (cx9 <= fx9 + 9'd15)
                       && (cy8 >= fy8) && (cy8 <= fy8 + 8'd15);

    // A y below the pre-move value means the speed step wrapped the 7-bit position.
    assign miss = (fruit_y_position >= 7'(BOTTOM_Y)) || (fruit_y_position < prev_y);

    // NOTE: every output and next_state gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        new_fruit   = 1'b0;
        draw_fruit  = 1'b0;
        erase_fruit = 1'b0;
        move_fruit  = 1'b0;
        case (state)
            S_IDLE, S_GAME_OVER: if (start) next_state = S_NEW;
            S_NEW: begin
                new_fruit  = 1'b1;
                next_state = S_DRAW;
            end
            S_DRAW: begin
                draw_fruit = 1'b1;
                if (fruit_drawn) next_state = S_GAP_D;
            end
            S_GAP_D: next_state = S_WAIT;
            S_WAIT:  if (frame_tick && last_move) next_state = S_ERASE;
            S_ERASE: begin
                draw_fruit  = 1'b1;
                erase_fruit = 1'b1;
                if (fruit_drawn) next_state = S_GAP_E;
            end
            S_GAP_E: next_state = cut_flag ? S_NEW : S_MOVE;
            S_MOVE: begin
                move_fruit = 1'b1;
                next_state = S_CHECK;
            end
            S_CHECK: begin
                if (miss) next_state = (lives == 2'd1) ? S_GAME_OVER : S_NEW;
                else      next_state = S_DRAW;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign plot      = draw_fruit;
    assign game_over = (state == S_GAME_OVER);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state                <= S_IDLE;
            frame_cnt            <= '0;
            move_cnt             <= '0;
            cut_flag             <= 1'b0;
            prev_y               <= '0;
            lives                <= '0;
            number_of_fruits_cut <= '0;
        end else begin
            state <= next_state;

            if (state != S_WAIT) begin
                frame_cnt <= '0;
                move_cnt  <= '0;
            end else if (wait_run) begin
                if (frame_tick) begin
                    frame_cnt <= '0;
                    move_cnt  <= last_move ? '0 : move_cnt + MW'(1);
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            if (state == S_NEW)          cut_flag <= 1'b0;
            else if (wait_run && hit)    cut_flag <= 1'b1;

            if (state == S_GAP_E && !cut_flag) prev_y <= fruit_y_position;

            if ((state == S_IDLE || state == S_GAME_OVER) && start) begin
                lives                <= 2'(START_LIVES);
                number_of_fruits_cut <= '0;
            end else if (state == S_GAP_E && cut_flag && number_of_fruits_cut != 8'hFF) begin
                number_of_fruits_cut <= number_of_fruits_cut + 8'd1;
            end else if (state == S_CHECK && miss) begin
                lives <= lives - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fruit_control.sv
// Directed bench for fruit_control with a small fruit datapath model (pixel counter, x/y registers).
module tb_fruit_control;

    localparam int SIG_NEW = 0, SIG_DRAW = 1, SIG_ERASE = 2, SIG_MOVE = 3, SIG_GO = 4;

    logic       clock = 1'b0;
    logic       resetn, start, slice;
    logic [7:0] cursor_x;
    logic [6:0] cursor_y;
    logic       new_fruit, draw_fruit, erase_fruit, move_fruit, plot, game_over;
    logic [7:0] number_of_fruits_cut;
    logic [1:0] lives;
`ifdef FRUIT_CTRL_PAUSE_EN
    logic       pause;
`endif

    // datapath model state and bench knobs
    logic [7:0] fx;
    logic [6:0] fy;
    logic [8:0] pix;
    logic       fruit_drawn;
    logic [7:0] spawn_x;
    logic [6:0] spawn_y, step, target;
    logic       use_target;
    int         draw_len;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fruit_control #(.FRAME_TICKS(4), .FRAMES_PER_MOVE(2)) dut (
        .clock(clock), .resetn(resetn), .start(start), .fruit_drawn(fruit_drawn),
        .fruit_x_position(fx), .fruit_y_position(fy),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .slice(slice),
`ifdef FRUIT_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .new_fruit(new_fruit), .draw_fruit(draw_fruit), .erase_fruit(erase_fruit),
        .move_fruit(move_fruit), .plot(plot), .number_of_fruits_cut(number_of_fruits_cut),
        .lives(lives), .game_over(game_over)
    );

    assign fruit_drawn = draw_fruit && (int'(pix) == draw_len - 1);

    always @(posedge clock) begin
        if (!resetn) begin
            pix <= '0;
            fx  <= '0;
            fy  <= '0;
        end else begin
            pix <= draw_fruit ? pix + 9'd1 : 9'd0;
            if (new_fruit) begin
                fx <= spawn_x;
                fy <= spawn_y;
            end else if (move_fruit) begin
                fy <= use_target ? target : fy + step;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SIG_NEW:   return new_fruit;
            SIG_DRAW:  return draw_fruit;
            SIG_ERASE: return erase_fruit;
            SIG_MOVE:  return move_fruit;
            default:   return game_over;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic level, input int max, input string tag);
        int n = 0;
        while (sig(sel) !== level && n < max) begin
            tick();
            n++;
        end
        if (sig(sel) !== level) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic to_gap_d();
        wait_for(SIG_DRAW, 1'b1, 2000, "draw_rise");
        wait_for(SIG_DRAW, 1'b0, 2000, "draw_fall");
    endtask

    task automatic to_gap_e();
        wait_for(SIG_ERASE, 1'b1, 2000, "erase_rise");
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
    endtask

    initial begin
        int n;
        resetn = 1'b0; start = 1'b0; slice = 1'b0; cursor_x = '0; cursor_y = '0;
        spawn_x = 8'd40; spawn_y = 7'd20; step = 7'd0; target = 7'd0; use_target = 1'b0;
        draw_len = 256;
`ifdef FRUIT_CTRL_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) tick();
        check("rst_cmds", {new_fruit, draw_fruit, erase_fruit, move_fruit, plot, game_over}, 0);
        check("rst_lives", lives, 0);
        check("rst_count", number_of_fruits_cut, 0);

        // Start: new_fruit pulse, 256-cycle draw, erase 8 cycles after WAIT entry.
        resetn = 1'b1;
        tick();
        check("idle_no_start", new_fruit, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_new", new_fruit, 1);
        check("start_lives", lives, 3);
        check("start_count", number_of_fruits_cut, 0);
        tick();
        check("new_one_cycle", {new_fruit, draw_fruit}, 2'b01);
        n = 0;
        while (draw_fruit && n < 1000) begin
            if (plot !== draw_fruit) check("plot_eq_draw", plot, draw_fruit);
            tick();
            n++;
        end
        check("draw_len", n, 256);
        check("gap_d_idle", {new_fruit, draw_fruit, move_fruit}, 0);
        tick();
        n = 0;
        while (!erase_fruit && n < 100) begin
            tick();
            n++;
        end
        check("wait_to_erase", n, 8);
        check("erase_with_draw", {draw_fruit, plot}, 2'b11);
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
        tick();
        check("move_no_cut", move_fruit, 1);
        tick();
        check("check_no_cmd", {move_fruit, draw_fruit}, 0);
        tick();
        check("redraw", draw_fruit, 1);

        // Slice at the far sprite corner (55,35) counts.
        to_gap_d();
        cursor_x = 8'd55; cursor_y = 7'd35; slice = 1'b1;
        wait_for(SIG_ERASE, 1'b1, 2000, "erase_rise");
        slice = 1'b0;
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
        check("cut_pending", number_of_fruits_cut, 0);
        tick();
        check("cut_new", {new_fruit, move_fruit}, 2'b10);
        check("cut_count1", number_of_fruits_cut, 1);

        // One pixel past the edge (56,35) misses the sprite.
        to_gap_d();
        cursor_x = 8'd56; slice = 1'b1;
        wait_for(SIG_ERASE, 1'b1, 2000, "erase_rise");
        slice = 1'b0;
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
        tick();
        check("edge_no_cut_move", move_fruit, 1);
        check("edge_count", number_of_fruits_cut, 1);
        tick(); tick();

        // Slice inside the sprite but only during DRAW and ERASE is ignored.
        cursor_x = 8'd45; cursor_y = 7'd25; slice = 1'b1;
        wait_for(SIG_DRAW, 1'b0, 2000, "draw_fall");
        slice = 1'b0;
        wait_for(SIG_ERASE, 1'b1, 2000, "erase_rise");
        slice = 1'b1;
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
        tick();
        slice = 1'b0;
        check("outside_wait_ignored", move_fruit, 1);
        tick(); tick();

        // Slice only in the final WAIT cycle at the top-left corner still counts.
        to_gap_d();
        cursor_x = 8'd40; cursor_y = 7'd20;
        repeat (8) tick();
        check("last_wait_cycle", erase_fruit, 0);
        slice = 1'b1;
        tick();
        slice = 1'b0;
        check("erase_after_tick", erase_fruit, 1);
        spawn_y = 7'd100; use_target = 1'b1; target = 7'd103;
        wait_for(SIG_ERASE, 1'b0, 2000, "erase_fall");
        tick();
        check("final_tick_cut", {new_fruit, number_of_fruits_cut}, {1'b1, 8'd2});

        // y=103 is on screen, y=104 is a miss, then 100->106 is a miss.
        to_gap_d(); to_gap_e();
        tick(); tick(); tick();
        check("y103_no_miss", {draw_fruit, lives}, {1'b1, 2'd3});
        target = 7'd104;
        to_gap_d(); to_gap_e();
        tick(); tick(); tick();
        check("y104_miss", {new_fruit, lives}, {1'b1, 2'd2});
        target = 7'd106;
        to_gap_d(); to_gap_e();
        tick(); tick(); tick();
        check("y106_miss", {new_fruit, lives}, {1'b1, 2'd1});

        // 120 -> 5 wrap caught via prev_y; last life ends the game.
        spawn_y = 7'd120; target = 7'd5;
        to_gap_d(); to_gap_e();
        tick(); tick(); tick();
        check("wrap_game_over", {game_over, new_fruit, lives}, {1'b1, 1'b0, 2'd0});
        check("go_count_held", number_of_fruits_cut, 2);
        repeat (3) tick();
        check("go_stays", game_over, 1);
        spawn_x = 8'd40; spawn_y = 7'd20; use_target = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart", {new_fruit, game_over, lives, number_of_fruits_cut}, {1'b1, 1'b0, 2'd3, 8'd0});

        // Fast datapath and a constant slice drive the count to saturation.
        draw_len = 4; cursor_x = 8'd47; cursor_y = 7'd27; slice = 1'b1;
        n = 0;
        while (number_of_fruits_cut != 8'd255 && n < 20000) begin
            tick();
            n++;
        end
        check("count_reach_255", number_of_fruits_cut, 255);
        wait_for(SIG_NEW, 1'b0, 100, "new_fall");
        wait_for(SIG_NEW, 1'b1, 200, "new_rise");
        check("count_saturate", number_of_fruits_cut, 255);
        check("sat_lives", lives, 3);

        // Reset asserted mid-DRAW.
        slice = 1'b0; draw_len = 256;
        wait_for(SIG_DRAW, 1'b1, 200, "draw_rise");
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        check("midrst_cmds", {draw_fruit, plot, new_fruit, game_over}, 0);
        check("midrst_regs", {lives, number_of_fruits_cut}, 0);
        resetn = 1'b1;
        tick();
        check("midrst_idle", {new_fruit, draw_fruit}, 0);

`ifdef FRUIT_CTRL_PAUSE_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        to_gap_d();
        tick();
        pause = 1'b1;
        repeat (20) tick();
        check("pause_hold", erase_fruit, 0);
        pause = 1'b0;
        n = 0;
        while (!erase_fruit && n < 100) begin
            tick();
            n++;
        end
        check("pause_delay", n, 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
